// File: rtl/fetch_controller_pkg.sv
// Fetch controller shared definitions.
// Word length macro, FSM codes, counter sizes.
`ifndef FETCH_CONTROLLER_DEFINES
`define FETCH_CONTROLLER_DEFINES
`define WORD_LEN 16
`endif

package fetch_controller_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] STATE_RUN   = 2'd0;
    localparam logic [1:0] STATE_STALL = 2'd1;
    localparam logic [1:0] STATE_FLUSH = 2'd2;

    localparam logic [15:0] SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/fetch_controller_sat.sv
// 16-bit saturating event counter.
// Counts enabled cycles, sticks at all-ones.
module sat_counter16
    import fetch_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);

    // Increment on enable until the ceiling is hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en && count != SAT_MAX)
            count <= count + 16'd1;
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch stage hazard/redirect sequencer.
// Stalls on load-use, flushes IF/ID on redirect.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hazard,
    input  logic                 brCondID,
    input  logic                 jumpID,
    input  logic [`WORD_LEN-1:0] brOffsetID,
    output logic                 brTaken,
    output logic                 jumpEnable,
    output logic [`WORD_LEN-1:0] brOffset,
    output logic                 freeze,
    output logic                 freezeIFID,
    output logic                 flushIFID,
    output logic                 bubbleIDEX,
    output logic [1:0]           state,
    output logic [15:0]          stallCount,
    output logic [15:0]          flushCount
);

    // Counter holds the cycles left after the current one
    localparam logic [CNT_W-1:0] STALL_LOAD =
        CNT_W'(STALL_CYCLES > 1 ? STALL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] FLUSH_LOAD =
        CNT_W'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

    logic [1:0]       stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;

    // Next state, counter and control decode; all forced low in reset
    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        brTaken    = 1'b0;
        jumpEnable = 1'b0;
        brOffset   = '0;
        freeze     = 1'b0;
        freezeIFID = 1'b0;
        flushIFID  = 1'b0;
        bubbleIDEX = 1'b0;
        case (stateQ)
            STATE_RUN: begin
                if (hazard) begin
                    freeze     = 1'b1;
                    freezeIFID = 1'b1;
                    bubbleIDEX = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        stateD = STATE_STALL;
                        cntD   = STALL_LOAD;
                    end
                end else if (jumpID || brCondID) begin
                    jumpEnable = jumpID;
                    brTaken    = ~jumpID;
                    flushIFID  = 1'b1;
                    brOffset   = brOffsetID;
                    if (FLUSH_CYCLES > 1) begin
                        stateD = STATE_FLUSH;
                        cntD   = FLUSH_LOAD;
                    end
                end
            end
            STATE_STALL: begin
                freeze     = 1'b1;
                freezeIFID = 1'b1;
                bubbleIDEX = 1'b1;
                if (cntQ == '0)
                    stateD = STATE_RUN;
                else
                    cntD = cntQ - CNT_W'(1);
            end
            STATE_FLUSH: begin
                flushIFID = 1'b1;
                if (cntQ == '0)
                    stateD = STATE_RUN;
                else
                    cntD = cntQ - CNT_W'(1);
            end
            default: begin
                stateD = STATE_RUN;
                cntD   = '0;
            end
        endcase
        if (rst) begin
            brTaken    = 1'b0;
            jumpEnable = 1'b0;
            brOffset   = '0;
            freeze     = 1'b0;
            freezeIFID = 1'b0;
            flushIFID  = 1'b0;
            bubbleIDEX = 1'b0;
        end
    end

    // FSM state and sequence counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= STATE_RUN;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    assign state = stateQ;

    sat_counter16 uStallCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (bubbleIDEX),
        .count (stallCount)
    );

    sat_counter16 uFlushCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flushIFID),
        .count (flushCount)
    );

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter STALL_CYCLES, default 1: consecutive bubble cycles per detected hazard; legal range 1..15.
REQ-002 Parameter FLUSH_CYCLES, default 1: consecutive IF/ID flush cycles per redirect, counting the redirect cycle; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 hazard  input  1  load-use hazard detected for the instruction in ID.
REQ-006 brCondID  input  1  branch in ID resolved taken.
REQ-007 jumpID  input  1  jump in ID.
REQ-008 brOffsetID  input  `WORD_LEN  branch/jump offset from ID.
REQ-009 brTaken  output  1  IF adder selects the branch offset.
REQ-010 jumpEnable  output  1  IF PC mux selects the jump target.
REQ-011 brOffset  output  `WORD_LEN  offset forwarded to IF.
REQ-012 freeze  output  1  holds the PC register.
REQ-013 freezeIFID  output  1  holds the IF/ID register.
REQ-014 flushIFID  output  1  loads a NOP into IF/ID at the next edge.
REQ-015 bubbleIDEX  output  1  loads a NOP into ID/EX at the next edge.
REQ-016 state  output  2  current FSM state code.
REQ-017 stallCount, flushCount  output  16 each  performance counters.

Function
REQ-018 The FSM SHALL have three states: RUN=0, STALL=1, FLUSH=2; code 3 is unreachable and SHALL recover to RUN at the next edge.
REQ-019 In RUN with hazard=1: freeze, freezeIFID and bubbleIDEX SHALL be 1 in that cycle.
REQ-020 In RUN with hazard=1, the next state SHALL be STALL when STALL_CYCLES>1, otherwise RUN.
REQ-021 In RUN with hazard=1, brCondID and jumpID SHALL be ignored (hazard has priority over redirect).
REQ-022 In RUN with hazard=0 and jumpID=1: jumpEnable=1, brTaken=0, flushIFID=1, brOffset=brOffsetID, all combinationally in the same cycle.
REQ-023 In RUN with hazard=0, jumpID=0 and brCondID=1: brTaken=1, jumpEnable=0, flushIFID=1, brOffset=brOffsetID, all combinationally.
REQ-024 On a redirect, the next state SHALL be FLUSH when FLUSH_CYCLES>1, otherwise RUN.
REQ-025 STALL SHALL last exactly STALL_CYCLES-1 cycles, driving freeze=freezeIFID=bubbleIDEX=1, then return to RUN.
REQ-026 FLUSH SHALL last exactly FLUSH_CYCLES-1 cycles, driving flushIFID=1 with freeze=0, then return to RUN.
REQ-027 In STALL and FLUSH, hazard, brCondID and jumpID SHALL be ignored; brTaken=jumpEnable=0 and brOffset=0.
REQ-028 In RUN with no event, all control outputs and brOffset SHALL be 0.
REQ-029 A 4-bit down-counter SHALL be loaded on STALL/FLUSH entry and SHALL not wrap below 0.
REQ-030 stallCount SHALL increment by 1 per cycle with bubbleIDEX=1.
REQ-031 flushCount SHALL increment by 1 per cycle with flushIFID=1.
REQ-032 Both counters SHALL saturate at 16'hFFFF.
REQ-033 Back-to-back events SHALL be honoured: an event in the first RUN cycle after STALL/FLUSH exit SHALL be acted on in that cycle.

Reset
REQ-034 While rst=1, state=RUN, the counter=0, stallCount=flushCount=0, and every control output and brOffset SHALL be 0, irrespective of the other inputs.
REQ-035 Reset asserted mid-STALL or mid-FLUSH SHALL abort the sequence immediately.
REQ-036 After reset deasserts, the first edge SHALL evaluate the inputs in RUN.

Structure
REQ-037 The state codes, the counter width and the 16-bit counter saturation constant SHALL be defined in the shared defines include, alongside `WORD_LEN.
REQ-038 One sub-module, sat_counter16 (saturating incrementer with synchronous enable and async reset), SHALL be instantiated twice.
REQ-039 The FSM and sequencing logic SHALL stay flat within fetch_controller.

Verification
REQ-040 Reset release, 5 idle cycles -> all outputs 0, state=0, both counters 0.
REQ-041 STALL_CYCLES=3, hazard pulse for 1 cycle -> freeze/bubbleIDEX high for 3 cycles, stallCount=3, state sequence 0,1,1,0.
REQ-042 brCondID=1 with brOffsetID=16'h0008, FLUSH_CYCLES=2 -> brTaken=1 and brOffset=16'h0008 in cycle 0, flushIFID high for 2 cycles, flushCount=2.
REQ-043 hazard=1, jumpID=1 and brCondID=1 in the same cycle -> stall only, jumpEnable=0, brTaken=0; jumpID held -> jumpEnable=1 in the first RUN cycle after the stall.
REQ-044 rst asserted in the second cycle of STALL (STALL_CYCLES=4) -> outputs 0 immediately, state=0 after release.
REQ-045 Force 70000 bubble cycles -> stallCount holds 16'hFFFF.
